multicycle_ctrl: RTL

Main control FSM for the multicycle RV32I+F core. It sequences the shared datapath (one memory port, one ALU, instruction register) across fetch, decode, execute, memory and writeback cycles. It also handshakes with the iterative FPU for OP-FP instructions and routes flw/fsw through the shared memory states.

---
 rtl/multicycle_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM for the multicycle RV32I+F core. It sequences the shared
// datapath (single memory port, single ALU, instruction register) through
// fetch, decode, execute, memory and writeback cycles. It also hands OP-FP
// instructions to the iterative FPU and routes flw/fsw through the same
// memory states as lw/sw.
//
// Ports:
//   clk        in   1  core clock, rising edge
//   reset_n    in   1  asynchronous active-low reset
//   op         in   7  opcode field of the instruction register
//   zero       in   1  ALU zero flag (meaningful in BEQ)
//   fpu_done   in   1  FPU result-valid pulse
//   PCWrite    out  1  PC enable = PCUpdate | (Branch & zero)
//   AdrSrc     out  1  memory address mux: 0=PC, 1=ALUOut
//   MemWrite   out  1  data memory write strobe
//   IRWrite    out  1  instruction register load
//   ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out  2  00 PC, 01 OldPC, 10 rs1, 11 constant 0
//   ALUSrcB    out  2  00 rs2, 01 imm, 10 constant 4
//   ALUOp      out  2  00 add, 01 sub/branch, 10 funct-decoded
//   ImmSrc     out  3  000 I, 001 S, 010 B, 011 J, 100 U (from op)
//   RegWrite   out  1  integer register file write
//   FRegWrite  out  1  FP register file write
//   FStoreSel  out  1  store data taken from FP register file
//   fpu_start  out  1  one-cycle FPU launch pulse
//   illegal    out  1  sticky trap flag (cleared only by reset)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned FP_TIMEOUT = 64,  // max FPWAIT cycles before trapping (>=2)
  parameter int unsigned CNT_W      = 7    // wait counter width, must hold FP_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       fpu_done,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       FRegWrite,
  output logic       FStoreSel,
  output logic       fpu_start,
  output logic       illegal
);

  // ---------------------------------------------------------------------------
  // Opcodes
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_FLW   = 7'b0000111;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_FSW   = 7'b0100111;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_FP    = 7'b1010011;

  // Last counter value at which FPWAIT may still be waiting; seeing it without
  // fpu_done means FP_TIMEOUT wait cycles have elapsed.
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(FP_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // State encoding: exactly 16 states in a 4-bit register
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_LUI      = 4'd11,
    S_FPSTART  = 4'd12,
    S_FPWAIT   = 4'd13,
    S_FPWB     = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  // Moore control word held in the output register.
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       freg_write;
    logic       fstore_sel;
    logic       fpu_start;
    logic       illegal;
  } ctrl_t;

  // Reset value of the output register is the FETCH control word, so the
  // first cycle after reset release already drives a proper fetch. Strobes are
  // additionally gated by reset_n below so nothing fires while in reset.
  localparam ctrl_t CTRL_RESET = '{
    pc_update:  1'b1,
    branch:     1'b0,
    adr_src:    1'b0,
    mem_write:  1'b0,
    ir_write:   1'b1,
    result_src: 2'b10,
    alu_src_a:  2'b00,
    alu_src_b:  2'b10,
    alu_op:     2'b00,
    reg_write:  1'b0,
    freg_write: 1'b0,
    fstore_sel: 1'b0,
    fpu_start:  1'b0,
    illegal:    1'b0
  };

  // Control word for a given state; fp selects the FP variant of the shared
  // load/store states.
  function automatic ctrl_t state_outputs(input state_e st, input logic fp);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.adr_src    = 1'b0;
        c.ir_write   = 1'b1;
        c.alu_src_a  = 2'b00;
        c.alu_src_b  = 2'b10;
        c.alu_op     = 2'b00;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = 2'b00;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = ~fp;
        c.freg_write = fp;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.fstore_sel = fp;
      end
      S_EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.result_src = 2'b00;
        c.reg_write  = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.alu_op     = 2'b00;
        c.result_src = 2'b00;
        c.pc_update  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = 2'b10;
        c.alu_src_b  = 2'b00;
        c.alu_op     = 2'b01;
        c.result_src = 2'b00;
        c.branch     = 1'b1;
      end
      S_LUI: begin
        c.alu_src_a = 2'b11;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
      end
      S_FPSTART: begin
        c.fpu_start = 1'b1;
      end
      S_FPWAIT: begin
        c = '0;
      end
      S_FPWB: begin
        c.freg_write = 1'b1;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and next-state signals
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             fp_q,    fp_d;
  ctrl_t            ctrl_q,  ctrl_d;

  // Next-state, FP flag and FPU wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fp_d    = fp_q;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        fp_d = (op == OP_FLW) || (op == OP_FSW);
        case (op)
          OP_LW, OP_FLW, OP_SW, OP_FSW: state_d = S_MEMADR;
          OP_RTYPE:                     state_d = S_EXECUTER;
          OP_IALU:                      state_d = S_EXECUTEI;
          OP_JAL:                       state_d = S_JAL;
          OP_BEQ:                       state_d = S_BEQ;
          OP_LUI:                       state_d = S_LUI;
          OP_FP:                        state_d = S_FPSTART;
          default:                      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        // op is held by the instruction register; anything that is no longer
        // a load or store here is treated as corrupted and trapped.
        if ((op == OP_LW) || (op == OP_FLW)) begin
          state_d = S_MEMREAD;
        end else if ((op == OP_SW) || (op == OP_FSW)) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
      end
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ, S_FPWB: begin
        state_d = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI: begin
        state_d = S_ALUWB;
      end
      S_FPSTART: begin
        cnt_d   = '0;
        state_d = S_FPWAIT;
      end
      S_FPWAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
        // A done pulse in the timeout cycle still completes the instruction.
        if (fpu_done) begin
          state_d = S_FPWB;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_FPWAIT;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // Control word for the state being entered, so the registered outputs line
  // up with the state register.
  always_comb begin
    ctrl_d = state_outputs(state_d, fp_d);
  end

  // FSM state, FP flag, wait counter and registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      fp_q    <= 1'b0;
      ctrl_q  <= CTRL_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fp_q    <= fp_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Immediate format decoded straight from the opcode.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_LW, OP_FLW, OP_IALU: ImmSrc = 3'b000;
      OP_SW, OP_FSW:          ImmSrc = 3'b001;
      OP_BEQ:                 ImmSrc = 3'b010;
      OP_JAL:                 ImmSrc = 3'b011;
      OP_LUI:                 ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Write strobes are masked by reset_n so an assertion of reset
  // kills them immediately, before the flops have settled to their reset
  // values, and keeps them low for the whole reset period.
  // ---------------------------------------------------------------------------
  assign PCWrite   = reset_n & (ctrl_q.pc_update | (ctrl_q.branch & zero));
  assign MemWrite  = reset_n & ctrl_q.mem_write;
  assign IRWrite   = reset_n & ctrl_q.ir_write;
  assign RegWrite  = reset_n & ctrl_q.reg_write;
  assign FRegWrite = reset_n & ctrl_q.freg_write;
  assign fpu_start = reset_n & ctrl_q.fpu_start;

  assign AdrSrc    = ctrl_q.adr_src;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ALUOp     = ctrl_q.alu_op;
  assign FStoreSel = ctrl_q.fstore_sel;
  assign illegal   = ctrl_q.illegal;

endmodule
